// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: drives the PC register, fetches from instruction memory and buffers each instruction for decode
module pc_fetch_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter int                INC       = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [3:0]        HALT_OPC  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_pc_cur,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_pc_wen,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [ADDR_W-1:0] i_imem_data,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_tgt,
  output logic [ADDR_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_instr_valid,
  output logic              o_halted
);
  typedef enum logic [1:0] {INIT, FETCH, HOLD, HALT} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_instr, r_instr_pc;
  logic r_valid, r_halted;
  logic w_redir, w_ack, w_ack_halt, w_buf_halt, w_consume;
  always_comb begin
    w_redir    = i_redirect & (r_state == FETCH | r_state == HOLD);
    w_ack      = (r_state == FETCH) & i_imem_ack & ~w_redir;
    w_ack_halt = i_imem_data[ADDR_W-1 -: 4] == HALT_OPC;
    w_buf_halt = r_instr[ADDR_W-1 -: 4] == HALT_OPC;
    w_consume  = (r_state == HOLD) & ~i_stall;
    o_pc_next  = w_redir ? (i_redirect_tgt & ~ADDR_W'(1)) :
                 (r_state == INIT) ? RESET_VEC : i_pc_cur + ADDR_W'(INC);
    // the PC register must not be written while reset holds the FSM in INIT
    o_pc_wen    = rst_n & ((r_state == INIT) | w_redir | (w_ack & ~w_ack_halt));
    o_imem_req  = (r_state == FETCH) & ~w_redir;
    o_imem_addr = i_pc_cur;
    w_next = (r_state == INIT || w_redir) ? FETCH :
             w_ack ? HOLD :
             w_consume ? (w_buf_halt ? HALT : FETCH) : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= r_halted | (w_next == HALT);
      if (w_ack) begin
        r_instr    <= i_imem_data;
        r_instr_pc <= i_pc_cur;
        r_valid    <= 1'b1;
      end else if (w_redir | w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_valid;
  assign o_halted      = r_halted;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed stimulus with a PC register and memory model; scoreboard monitor checks decoded instructions
module tb_pc_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] pc_cur, pc_next, imem_addr, imem_data, tgt, instr, instr_pc;
  logic pc_wen, imem_req, imem_ack, stall, redirect, instr_valid, halted, force_ack;
  int mem_wait, cnt, n_cmp, n_bad;
  logic [15:0] mem [0:32767];
  logic [31:0] sb [$];

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_pc_cur(pc_cur), .o_pc_next(pc_next), .o_pc_wen(pc_wen),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .i_imem_data(imem_data),
    .i_stall(stall), .i_redirect(redirect), .i_redirect_tgt(tgt), .o_instr(instr),
    .o_instr_pc(instr_pc), .o_instr_valid(instr_valid), .o_halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc_cur <= 16'hBEEF;
    else if (pc_wen) pc_cur <= pc_next;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 0;
    else cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;

  assign imem_ack  = force_ack | (imem_req && cnt >= mem_wait);
  assign imem_data = mem[imem_addr[15:1]];

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic pv;
    logic [31:0] e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && !pv) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_instr: got %h at %h expected none", instr, instr_pc);
        end else begin
          e = sb.pop_front();
          chk16("sb_instr", instr, e[31:16]);
          chk16("sb_instr_pc", instr_pc, e[15:0]);
        end
      end
      pv = instr_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; tgt = '0; force_ack = 1'b0; mem_wait = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h2000 ^ 16'(i);
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'h6666;
    mem[8] = 16'hF000; mem[16'h20] = 16'h4444; mem[16'h7FFF] = 16'h7777;
    tick; tick;
    #1;
    chk1("rst_req", imem_req, 1'b0); chk1("rst_wen", pc_wen, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0); chk1("rst_halted", halted, 1'b0);
    chk16("rst_instr", instr, 16'h0); chk16("rst_instr_pc", instr_pc, 16'h0);
    rst_n = 1'b1;
    #1 chk1("init_wen", pc_wen, 1'b1); chk16("init_next", pc_next, 16'h0000);
    tick; sb.push_back({16'h1234, 16'h0000});
    #1 chk1("f0_req", imem_req, 1'b1); chk16("f0_addr", imem_addr, 16'h0000);
    chk1("f0_wen", pc_wen, 1'b1); chk16("f0_next", pc_next, 16'h0002);
    tick;
    #1 chk1("h0_req", imem_req, 1'b0); chk1("h0_wen", pc_wen, 1'b0);
    tick; sb.push_back({16'h5678, 16'h0002});
    #1 chk16("f2_addr", imem_addr, 16'h0002); chk16("f2_next", pc_next, 16'h0004);
    tick; mem_wait = 3;
    #1 chk1("h2_req", imem_req, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      #1 chk1("wait_req", imem_req, 1'b1); chk16("wait_addr", imem_addr, 16'h0004);
      chk1("wait_wen", pc_wen, 1'b0);
      tick;
    end
    sb.push_back({16'h9ABC, 16'h0004});
    #1 chk1("ack4_wen", pc_wen, 1'b1); chk16("ack4_next", pc_next, 16'h0006);
    tick; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk16("stall_instr", instr, 16'h9ABC); chk16("stall_pc", instr_pc, 16'h0004);
      chk1("stall_valid", instr_valid, 1'b1); chk1("stall_req", imem_req, 1'b0);
      chk1("stall_wen", pc_wen, 1'b0);
      tick;
    end
    stall = 1'b0;
    #1 chk1("unstall_valid", instr_valid, 1'b1); chk1("unstall_wen", pc_wen, 1'b0);
    tick; tick; tick; tick;
    redirect = 1'b1; tgt = 16'h0041; force_ack = 1'b1; mem_wait = 0;
    #1 chk1("redir_wen", pc_wen, 1'b1); chk16("redir_next", pc_next, 16'h0040);
    chk1("redir_req", imem_req, 1'b0);
    tick; redirect = 1'b0; force_ack = 1'b0; sb.push_back({16'h4444, 16'h0040});
    #1 chk1("redir_drop", instr_valid, 1'b0); chk16("redir_addr", imem_addr, 16'h0040);
    chk1("redir_req2", imem_req, 1'b1); chk16("redir_next2", pc_next, 16'h0042);
    tick; redirect = 1'b1; tgt = 16'hFFFF;
    #1 chk1("hredir_wen", pc_wen, 1'b1); chk16("hredir_next", pc_next, 16'hFFFE);
    tick; redirect = 1'b0; sb.push_back({16'h7777, 16'hFFFE});
    #1 chk1("hredir_valid", instr_valid, 1'b0); chk16("wrap_addr", imem_addr, 16'hFFFE);
    chk1("wrap_wen", pc_wen, 1'b1); chk16("wrap_next", pc_next, 16'h0000);
    tick;
    tick; sb.push_back({16'h1234, 16'h0000});
    #1 chk16("after_wrap_addr", imem_addr, 16'h0000);
    tick; redirect = 1'b1; tgt = 16'h0010;
    #1 chk16("to_halt_next", pc_next, 16'h0010);
    tick; redirect = 1'b0; sb.push_back({16'hF000, 16'h0010});
    #1 chk1("halt_req", imem_req, 1'b1); chk1("halt_ack_wen", pc_wen, 1'b0);
    chk16("halt_addr", imem_addr, 16'h0010);
    tick;
    #1 chk1("halt_hold_valid", instr_valid, 1'b1); chk1("halt_hold_halted", halted, 1'b0);
    chk1("halt_hold_wen", pc_wen, 1'b0);
    tick;
    #1 chk1("halted", halted, 1'b1); chk1("halted_valid", instr_valid, 1'b0);
    chk1("halted_req", imem_req, 1'b0); chk16("halted_pc", pc_cur, 16'h0010);
    redirect = 1'b1; tgt = 16'h0080;
    #1 chk1("halt_redir_wen", pc_wen, 1'b0); chk1("halt_redir_req", imem_req, 1'b0);
    tick; redirect = 1'b0;
    #1 chk1("halted_sticky", halted, 1'b1); chk16("halted_pc2", pc_cur, 16'h0010);
    rst_n = 1'b0;
    #1 chk1("rst2_halted", halted, 1'b0); chk1("rst2_wen", pc_wen, 1'b0);
    chk1("rst2_req", imem_req, 1'b0);
    tick; rst_n = 1'b1;
    #1 chk1("init2_wen", pc_wen, 1'b1); chk16("init2_next", pc_next, 16'h0000);
    tick; mem_wait = 3;
    #1 chk1("mid_req", imem_req, 1'b1); chk16("mid_addr", imem_addr, 16'h0000);
    chk1("mid_wen", pc_wen, 1'b0);
    rst_n = 1'b0;
    #1 chk1("mid_rst_req", imem_req, 1'b0); chk1("mid_rst_wen", pc_wen, 1'b0);
    tick; rst_n = 1'b1; mem_wait = 0;
    #1 chk1("init3_wen", pc_wen, 1'b1); chk16("init3_next", pc_next, 16'h0000);
    tick; sb.push_back({16'h1234, 16'h0000});
    #1 chk1("restart_req", imem_req, 1'b1); chk16("restart_next", pc_next, 16'h0002);
    tick; tick;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick;
    chk16("sb_drained", 16'(sb.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
